scm_3r2w_port_ctrl: RTL and testbench
=====================================

// Module: scm_3r2w_port_ctrl
// PURPOSE
//  Initiator-side controller driving a 3-read/2-write byte-enabled latch SCM.
//  - Converts three valid/ready read streams and two valid/ready write streams into raw SCM port strobes.
//  - Removes same-address write contention by merging colliding writes.
//  - Enforces read-after-write ordering.
//  - Holds read responses stable under backpressure.
//  - Sits between cluster-side requesters and the SCM macro.
// PARAMETERS
//  ADDR_WIDTH  5              SCM word address width
//  DATA_WIDTH  32             word width
//  NUM_BYTE    DATA_WIDTH/8   byte lanes
//  CNT_WIDTH   16             width of the collision counter
// PORTS
//  clk              in   1                 clock
//  rst_n            in   1                 synchronous active-low reset
//  wr_valid_i       in   2                 write request valid, ports A=0 B=1
//  wr_ready_o       out  2                 write request ready
//  wr_addr_i        in   2xADDR_WIDTH      write address
//  wr_data_i        in   2xDATA_WIDTH      write data
//  wr_be_i          in   2xNUM_BYTE        write byte enables
//  rd_req_valid_i   in   3                 read request valid, ports A/B/C
//  rd_req_ready_o   out  3                 read request ready
//  rd_req_addr_i    in   3xADDR_WIDTH      read address
//  rd_rsp_valid_o   out  3                 read response valid
//  rd_rsp_ready_i   in   3                 read response ready
//  rd_rsp_data_o    out  3xDATA_WIDTH      read response data
//  scm_re_o         out  3                 SCM ReadEnable per port
//  scm_raddr_o      out  3xADDR_WIDTH      SCM ReadAddr
//  scm_rdata_i      in   3xDATA_WIDTH      SCM ReadData (valid the cycle after scm_re_o)
//  scm_we_o         out  2                 SCM WriteEnable
//  scm_waddr_o      out  2xADDR_WIDTH      SCM WriteAddr
//  scm_wdata_o      out  2xDATA_WIDTH      SCM WriteData
//  scm_wbe_o        out  2xNUM_BYTE        SCM WriteBE
//  collision_cnt_o  out  CNT_WIDTH         count of merged write collisions
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - All ready/valid outputs, scm_re_o, scm_we_o and collision_cnt_o are 0.
//   - Read FSMs go to IDLE; hold registers are cleared to 0.
//   - An in-flight response is dropped; requesters must reissue.
//  Write path
//   - wr_ready_o = 2'b11 whenever out of reset; a write is accepted when wr_valid_i=1.
//   - SCM strobes are combinational in the accept cycle.
//   - An accepted write with wr_be_i==0 is accepted but drives scm_we_o=0.
//  Write collision
//   - Condition: both writes valid, same address, both BE non-zero.
//   - Port A issues the merged word: per byte, B data if be_B[j] else A data; BE = be_A|be_B.
//   - scm_we_o[1]=0.
//   - collision_cnt_o increments by 1 and saturates at all-ones.
//  Read FSM per port
//   - States: IDLE, RESP, HOLD.
//   - rd_req_ready_o[p] = (state==IDLE || rsp handshake this cycle) && !raw_block[p].
//   - raw_block[p]: rd_req_addr_i[p] equals the address of any write issued to the SCM this cycle.
//   - Accept -> scm_re_o[p]=1, scm_raddr_o[p]=addr, next state RESP. Latency = 1 cycle.
//   - RESP: rd_rsp_valid_o=1 and rd_rsp_data_o = scm_rdata_i[p] (live).
//     - If rd_rsp_ready_i: next state IDLE, or RESP on back-to-back accept.
//     - Else: capture scm_rdata_i into the hold register and go to HOLD.
//   - HOLD: data comes from the hold register, immune to later writes at that address.
//     - Exit on rd_rsp_ready_i, as from RESP.
//   - Throughput: 1 read per port per cycle with ready held high.
//  Outside accepts, scm_re_o[p]=0 so the SCM address register holds.
//  All widths are exact; no arithmetic other than the saturating counter.
// TESTING
//  - Reset: hold rst_n=0 2 cycles with all valids=1 -> all readies=0, scm_re_o=0, scm_we_o=0, cnt=0.
//  - Collision merge: wrA addr 3 data 0x11223344 be 0011, wrB addr 3 data 0xAABBCCDD be 0110, same cycle
//    -> scm_we_o=01, wdata=0xxxBBCC44 (byte3 don't care), wbe=0111, cnt=1; read addr 3 returns 0x00BBCC44 over zeroed word.
//  - RAW block: write addr 5 = 0xDEADBEEF while readA requests addr 5 -> rd_req_ready_o[0]=0 that cycle;
//    accepted next cycle, response 0xDEADBEEF 1 cycle later.
//  - Backpressure hold: read addr 7 (=0x1), rd_rsp_ready_i=0 for 4 cycles while addr 7 is rewritten to 0x2
//    -> response stays 0x1 until ready, then deasserts.
//  - Streaming: 8 back-to-back reads on all 3 ports, ready=1 -> one response per cycle per port, correct order.
//  - Saturation: force 2^CNT_WIDTH+3 collisions -> collision_cnt_o stays 0xFFFF.

Source files
------------

// File: rtl/scm_3r2w_port_ctrl.sv
// Port controller for a 3-read/2-write byte-enabled latch SCM: merges same-address writes,
// blocks reads that collide with a same-cycle write and holds read responses under backpressure.
`timescale 1ns/1ps
module scm_3r2w_port_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              wr_valid_i,
    output logic [1:0]              wr_ready_o,
    input  logic [2*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [2*DATA_WIDTH-1:0] wr_data_i,
    input  logic [2*NUM_BYTE-1:0]   wr_be_i,
    input  logic [2:0]              rd_req_valid_i,
    output logic [2:0]              rd_req_ready_o,
    input  logic [3*ADDR_WIDTH-1:0] rd_req_addr_i,
    output logic [2:0]              rd_rsp_valid_o,
    input  logic [2:0]              rd_rsp_ready_i,
    output logic [3*DATA_WIDTH-1:0] rd_rsp_data_o,
    output logic [2:0]              scm_re_o,
    output logic [3*ADDR_WIDTH-1:0] scm_raddr_o,
    input  logic [3*DATA_WIDTH-1:0] scm_rdata_i,
    output logic [1:0]              scm_we_o,
    output logic [2*ADDR_WIDTH-1:0] scm_waddr_o,
    output logic [2*DATA_WIDTH-1:0] scm_wdata_o,
    output logic [2*NUM_BYTE-1:0]   scm_wbe_o,
    output logic [CNT_WIDTH-1:0]    collision_cnt_o
);

    typedef enum logic [1:0] {StIdle, StResp, StHold} rdState_e;

    logic [ADDR_WIDTH-1:0] addrA, addrB;
    logic [DATA_WIDTH-1:0] dataA, dataB, mergedData;
    logic [NUM_BYTE-1:0]   beA, beB;
    logic                  weA, weB, collide;
    logic [CNT_WIDTH-1:0]  cntQ;

    rdState_e              stateQ [3];
    rdState_e              stateD [3];
    logic [DATA_WIDTH-1:0] holdQ  [3];
    logic [2:0]            rawBlock, rspHs, accept, holdEn;

    assign addrA = wr_addr_i[0 +: ADDR_WIDTH];
    assign addrB = wr_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
    assign dataA = wr_data_i[0 +: DATA_WIDTH];
    assign dataB = wr_data_i[DATA_WIDTH +: DATA_WIDTH];
    assign beA   = wr_be_i[0 +: NUM_BYTE];
    assign beB   = wr_be_i[NUM_BYTE +: NUM_BYTE];

    always_comb begin
        collide = rst_n && (&wr_valid_i) && (addrA == addrB) && (|beA) && (|beB);
        weA     = rst_n && wr_valid_i[0] && (|beA);
        weB     = rst_n && wr_valid_i[1] && (|beB) && !collide;
        for (int unsigned j = 0; j < NUM_BYTE; j++) begin
            mergedData[j*8 +: 8] = beB[j] ? dataB[j*8 +: 8] : dataA[j*8 +: 8];
        end
    end

    assign wr_ready_o      = {2{rst_n}};
    assign scm_we_o        = {weB, weA};
    assign scm_waddr_o     = wr_addr_i;
    // On a collision port A carries the merged word and port B stays silent.
    assign scm_wdata_o     = {dataB, collide ? mergedData : dataA};
    assign scm_wbe_o       = {beB, collide ? (beA | beB) : beA};
    assign scm_raddr_o     = rd_req_addr_i;
    assign collision_cnt_o = cntQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntQ <= '0;
        end else if (collide && (cntQ != '1)) begin
            cntQ <= cntQ + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        rawBlock       = '0;
        rspHs          = '0;
        accept         = '0;
        holdEn         = '0;
        rd_req_ready_o = '0;
        rd_rsp_valid_o = '0;
        rd_rsp_data_o  = '0;
        scm_re_o       = '0;
        for (int p = 0; p < 3; p++) begin
            stateD[p] = stateQ[p];
            rawBlock[p] = (weA && (rd_req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == addrA)) ||
                          (weB && (rd_req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == addrB));
            rd_rsp_valid_o[p] = rst_n && (stateQ[p] != StIdle);
            rspHs[p]          = rd_rsp_valid_o[p] && rd_rsp_ready_i[p];
            rd_req_ready_o[p] = rst_n && ((stateQ[p] == StIdle) || rspHs[p]) && !rawBlock[p];
            accept[p]         = rd_req_ready_o[p] && rd_req_valid_i[p];
            scm_re_o[p]       = accept[p];
            rd_rsp_data_o[p*DATA_WIDTH +: DATA_WIDTH] =
                (stateQ[p] == StHold) ? holdQ[p] : scm_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            unique case (stateQ[p])
                StIdle: if (accept[p]) stateD[p] = StResp;
                StResp: begin
                    if (rd_rsp_ready_i[p]) begin
                        stateD[p] = accept[p] ? StResp : StIdle;
                    end else begin
                        // Freeze the word now so later writes to that address cannot leak in.
                        holdEn[p] = 1'b1;
                        stateD[p] = StHold;
                    end
                end
                StHold: if (rd_rsp_ready_i[p]) stateD[p] = accept[p] ? StResp : StIdle;
                default: stateD[p] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (!rst_n) begin
                stateQ[p] <= StIdle;
                holdQ[p]  <= '0;
            end else begin
                stateQ[p] <= stateD[p];
                if (holdEn[p]) holdQ[p] <= scm_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_scm_3r2w_port_ctrl.sv
// Bench for scm_3r2w_port_ctrl: behavioural latch SCM plus per-port response scoreboard.
`timescale 1ns/1ps
module tb_scm_3r2w_port_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      wr_valid_i;
    logic [1:0]      wr_ready_o;
    logic [2*AW-1:0] wr_addr_i;
    logic [2*DW-1:0] wr_data_i;
    logic [2*NB-1:0] wr_be_i;
    logic [2:0]      rd_req_valid_i;
    logic [2:0]      rd_req_ready_o;
    logic [3*AW-1:0] rd_req_addr_i;
    logic [2:0]      rd_rsp_valid_o;
    logic [2:0]      rd_rsp_ready_i;
    logic [3*DW-1:0] rd_rsp_data_o;
    logic [2:0]      scm_re_o;
    logic [3*AW-1:0] scm_raddr_o;
    logic [3*DW-1:0] scm_rdata_i;
    logic [1:0]      scm_we_o;
    logic [2*AW-1:0] scm_waddr_o;
    logic [2*DW-1:0] scm_wdata_o;
    logic [2*NB-1:0] scm_wbe_o;
    logic [CW-1:0]   collision_cnt_o;

    int nTests = 0;
    int nFail  = 0;
    int colTotal = 0;
    logic [DW-1:0] expQ [3][$];
    logic [DW-1:0] monExp;
    logic [DW-1:0] mem [32];
    logic [AW-1:0] raddrQ [3];

    always #5 clk = ~clk;

    scm_3r2w_port_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_req_addr_i(rd_req_addr_i), .rd_rsp_valid_o(rd_rsp_valid_o),
        .rd_rsp_ready_i(rd_rsp_ready_i), .rd_rsp_data_o(rd_rsp_data_o),
        .scm_re_o(scm_re_o), .scm_raddr_o(scm_raddr_o), .scm_rdata_i(scm_rdata_i),
        .scm_we_o(scm_we_o), .scm_waddr_o(scm_waddr_o), .scm_wdata_o(scm_wdata_o),
        .scm_wbe_o(scm_wbe_o), .collision_cnt_o(collision_cnt_o)
    );

    // Latch SCM model: read address registered on ReadEnable, read data follows current contents.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            for (int p = 0; p < 3; p++) raddrQ[p] <= '0;
        end else begin
            for (int p = 0; p < 3; p++)
                if (scm_re_o[p]) raddrQ[p] <= scm_raddr_o[p*AW +: AW];
            for (int w = 0; w < 2; w++)
                if (scm_we_o[w])
                    for (int j = 0; j < NB; j++)
                        if (scm_wbe_o[w*NB + j])
                            mem[scm_waddr_o[w*AW +: AW]][j*8 +: 8] <= scm_wdata_o[w*DW + j*8 +: 8];
        end
    end

    always_comb begin
        scm_rdata_i = '0;
        for (int p = 0; p < 3; p++) scm_rdata_i[p*DW +: DW] = mem[raddrQ[p]];
    end

    // Scoreboard: every response handshake pops the oldest expected word for that port.
    always @(negedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (rd_rsp_valid_o[p] && rd_rsp_ready_i[p]) begin
                nTests++;
                if (expQ[p].size() == 0) begin
                    nFail++;
                    $display("FAIL rsp_unexpected port %0d got %h required no response",
                             p, rd_rsp_data_o[p*DW +: DW]);
                end else begin
                    monExp = expQ[p].pop_front();
                    if (rd_rsp_data_o[p*DW +: DW] !== monExp) begin
                        nFail++;
                        $display("FAIL rsp_data port %0d got %h required %h",
                                 p, rd_rsp_data_o[p*DW +: DW], monExp);
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] streamVal(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {16'hC0DE, b, ~b};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid_i     = '0;
        wr_addr_i      = '0;
        wr_data_i      = '0;
        wr_be_i        = '0;
        rd_req_valid_i = '0;
        rd_req_addr_i  = '0;
        rd_rsp_ready_i = '0;
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        bit done = 0;
        rd_rsp_ready_i[p] = 1'b1;
        rd_req_addr_i[p*AW +: AW] = addr;
        rd_req_valid_i[p] = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (rd_req_ready_o[p]) begin
                expQ[p].push_back(exp);
                done = 1;
            end
            cyc();
        end
        rd_req_valid_i[p] = 1'b0;
        nTests++;
        if (!done) begin
            nFail++;
            $display("FAIL read_accept_timeout port %0d got no ready required ready", p);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 30; k++) begin
            if (expQ[0].size() == 0 && expQ[1].size() == 0 && expQ[2].size() == 0) break;
            cyc();
        end
        nTests++;
        if (expQ[0].size() + expQ[1].size() + expQ[2].size() != 0) begin
            nFail++;
            $display("FAIL drain_timeout got %0d outstanding required 0",
                     expQ[0].size() + expQ[1].size() + expQ[2].size());
            for (int p = 0; p < 3; p++) expQ[p].delete();
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        wr_valid_i     = 2'b11;
        wr_addr_i      = {5'd1, 5'd1};
        wr_data_i      = {32'h1, 32'h2};
        wr_be_i        = '1;
        rd_req_valid_i = 3'b111;
        rd_req_addr_i  = '0;
        rd_rsp_ready_i = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nTests++;
        if (wr_ready_o !== 2'b00) begin
            nFail++; $display("FAIL reset_wr_ready got %b required 00", wr_ready_o);
        end
        nTests++;
        if (rd_req_ready_o !== 3'b000) begin
            nFail++; $display("FAIL reset_rd_ready got %b required 000", rd_req_ready_o);
        end
        nTests++;
        if (scm_re_o !== 3'b000 || scm_we_o !== 2'b00) begin
            nFail++; $display("FAIL reset_strobes got re=%b we=%b required 0", scm_re_o, scm_we_o);
        end
        nTests++;
        if (collision_cnt_o !== 16'h0 || rd_rsp_valid_o !== 3'b000) begin
            nFail++;
            $display("FAIL reset_cnt_valid got cnt=%h valid=%b required 0", collision_cnt_o,
                     rd_rsp_valid_o);
        end
        cyc();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        nTests++;
        if (wr_ready_o !== 2'b11) begin
            nFail++; $display("FAIL wr_ready_after_reset got %b required 11", wr_ready_o);
        end
        cyc();
    endtask

    task automatic test_collision();
        wr_valid_i = 2'b11;
        wr_addr_i  = {5'd3, 5'd3};
        wr_data_i  = {32'hAABBCCDD, 32'h11223344};
        wr_be_i    = {4'b0110, 4'b0011};
        @(negedge clk);
        nTests++;
        if (scm_we_o !== 2'b01) begin
            nFail++; $display("FAIL collision_we got %b required 01", scm_we_o);
        end
        nTests++;
        if (scm_wdata_o[23:0] !== 24'hBBCC44) begin
            nFail++; $display("FAIL collision_wdata got %h required xxBBCC44", scm_wdata_o[31:0]);
        end
        nTests++;
        if (scm_wbe_o[3:0] !== 4'b0111) begin
            nFail++; $display("FAIL collision_wbe got %b required 0111", scm_wbe_o[3:0]);
        end
        cyc();
        colTotal++;
        wr_valid_i = 2'b00;
        @(negedge clk);
        nTests++;
        if (collision_cnt_o !== 16'd1) begin
            nFail++; $display("FAIL collision_cnt got %0d required 1", collision_cnt_o);
        end
        cyc();
        do_read(0, 5'd3, 32'h00BBCC44);
        wait_drain();
        idle_inputs();
    endtask

    task automatic test_raw_block();
        wr_valid_i = 2'b01;
        wr_addr_i  = {5'd0, 5'd5};
        wr_data_i  = {32'h0, 32'hDEADBEEF};
        wr_be_i    = {4'b0000, 4'b1111};
        rd_req_addr_i[0 +: AW] = 5'd5;
        rd_req_valid_i[0] = 1'b1;
        rd_rsp_ready_i[0] = 1'b1;
        @(negedge clk);
        nTests++;
        if (rd_req_ready_o[0] !== 1'b0 || scm_re_o[0] !== 1'b0) begin
            nFail++;
            $display("FAIL raw_block got ready=%b re=%b required 0", rd_req_ready_o[0], scm_re_o[0]);
        end
        cyc();
        wr_valid_i = 2'b00;
        @(negedge clk);
        nTests++;
        if (rd_req_ready_o[0] !== 1'b1) begin
            nFail++; $display("FAIL raw_release got %b required 1", rd_req_ready_o[0]);
        end
        expQ[0].push_back(32'hDEADBEEF);
        cyc();
        rd_req_valid_i[0] = 1'b0;
        @(negedge clk);
        nTests++;
        if (rd_rsp_valid_o[0] !== 1'b1) begin
            nFail++; $display("FAIL raw_latency got valid=%b required 1", rd_rsp_valid_o[0]);
        end
        cyc();
        wait_drain();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        wr_valid_i = 2'b01;
        wr_addr_i  = {5'd0, 5'd7};
        wr_data_i  = {32'h0, 32'h1};
        wr_be_i    = {4'b0000, 4'b1111};
        cyc();
        wr_valid_i = 2'b00;
        rd_req_addr_i[AW +: AW] = 5'd7;
        rd_req_valid_i[1] = 1'b1;
        rd_rsp_ready_i[1] = 1'b0;
        @(negedge clk);
        nTests++;
        if (rd_req_ready_o[1] !== 1'b1) begin
            nFail++; $display("FAIL bp_accept got %b required 1", rd_req_ready_o[1]);
        end
        cyc();
        rd_req_valid_i[1] = 1'b0;
        wr_valid_i = 2'b01;
        wr_data_i  = {32'h0, 32'h2};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nTests++;
            if (rd_rsp_valid_o[1] !== 1'b1 || rd_rsp_data_o[DW +: DW] !== 32'h1) begin
                nFail++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h required 1/00000001", i,
                         rd_rsp_valid_o[1], rd_rsp_data_o[DW +: DW]);
            end
            cyc();
            wr_valid_i = 2'b00;
        end
        rd_rsp_ready_i[1] = 1'b1;
        expQ[1].push_back(32'h1);
        cyc();
        @(negedge clk);
        nTests++;
        if (rd_rsp_valid_o[1] !== 1'b0) begin
            nFail++; $display("FAIL bp_release got valid=%b required 0", rd_rsp_valid_o[1]);
        end
        cyc();
        do_read(1, 5'd7, 32'h2);
        wait_drain();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k += 2) begin
            wr_valid_i = 2'b11;
            wr_addr_i  = {5'(9 + k), 5'(8 + k)};
            wr_data_i  = {streamVal(9 + k), streamVal(8 + k)};
            wr_be_i    = '1;
            cyc();
        end
        wr_valid_i     = 2'b00;
        rd_rsp_ready_i = 3'b111;
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 3; p++) begin
                rd_req_addr_i[p*AW +: AW] = 5'(8 + ((i + 3 * p) % 8));
                expQ[p].push_back(streamVal(8 + ((i + 3 * p) % 8)));
            end
            rd_req_valid_i = 3'b111;
            @(negedge clk);
            nTests++;
            if (rd_req_ready_o !== 3'b111) begin
                nFail++; $display("FAIL stream_ready beat %0d got %b required 111", i, rd_req_ready_o);
            end
            if (i > 0) begin
                nTests++;
                if (rd_rsp_valid_o !== 3'b111) begin
                    nFail++;
                    $display("FAIL stream_valid beat %0d got %b required 111", i, rd_rsp_valid_o);
                end
            end
            cyc();
        end
        rd_req_valid_i = 3'b000;
        wait_drain();
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [CW-1:0] expCnt;
        wr_valid_i = 2'b11;
        wr_addr_i  = {5'd20, 5'd20};
        wr_data_i  = {32'h5555_5555, 32'hAAAA_AAAA};
        wr_be_i    = {4'b0010, 4'b0001};
        for (int i = 0; i < 65539; i++) begin
            cyc();
            colTotal++;
            if (colTotal >= 65534 && colTotal <= 65536) begin
                expCnt = (colTotal > 65535) ? 16'hFFFF : 16'(colTotal);
                nTests++;
                if (collision_cnt_o !== expCnt) begin
                    nFail++;
                    $display("FAIL sat_cnt after %0d got %h required %h", colTotal,
                             collision_cnt_o, expCnt);
                end
            end
        end
        wr_valid_i = 2'b00;
        @(negedge clk);
        nTests++;
        if (collision_cnt_o !== 16'hFFFF) begin
            nFail++; $display("FAIL sat_final got %h required FFFF", collision_cnt_o);
        end
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_collision();
        test_raw_block();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
